// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode, funct7 and ALU operation definitions shared by the RV32I decoder
package ctrl_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SLL  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SRL  = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_op_t;

endpackage

// File: rtl/ctrl_imm_gen.sv
// ctrl_imm_gen: raw 12-bit immediate extraction, I-type or S-type layout
module ctrl_imm_gen
    import ctrl_pkg::*;
(
    input  logic [11:0] i_hi,
    input  logic [4:0]  i_rd,
    input  logic        i_sel_s,
    output logic [11:0] o_imm
);

    // S-type keeps the upper seven bits and takes its low five from the rd slot
    always_comb o_imm = i_sel_s ? {i_hi[11:5], i_rd} : i_hi;

endmodule

// File: rtl/control_unit.sv
// control_unit: registered RV32I decoder (immediate, rf write enable, ALU op);
// CTRL_ILLEGAL_FLAG_EN adds a registered 'illegal' output for unsupported instructions
module control_unit
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic [11:0] imm12,
    output logic        rf_we,
    output logic [2:0]  alu_op
`ifdef CTRL_ILLEGAL_FLAG_EN
    ,
    output logic        illegal
`endif
);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_shift;
    logic        w_op_imm;
    logic        w_load;
    logic        w_store;
    logic        w_op;
    logic [11:0] w_gen_imm;
    logic [11:0] w_imm;
    logic        w_we;
    alu_op_t     w_alu;
    logic        w_unused;

    logic [11:0] r_imm12;
    logic        r_rf_we;
    alu_op_t     r_alu_op;

    assign w_opc    = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];
    assign w_unused = ^instr[19:15];

    ctrl_imm_gen u_imm_gen (
        .i_hi    (instr[31:20]),
        .i_rd    (instr[11:7]),
        .i_sel_s (w_store),
        .o_imm   (w_gen_imm)
    );

    // Classify the instruction; shift immediates only accept the base funct7
    always_comb begin
        w_shift  = (w_f3 == ALU_SLL) || (w_f3 == ALU_SRL);
        w_op_imm = (w_opc == OPC_OP_IMM) && (!w_shift || (w_f7 == F7_BASE));
        w_load   = (w_opc == OPC_LOAD);
        w_store  = (w_opc == OPC_STORE);
        w_op     = (w_opc == OPC_OP) && (w_f7 == F7_BASE);
        w_imm    = (w_op_imm || w_load || w_store) ? w_gen_imm : 12'h000;
        w_we     = w_op_imm || w_load || w_op;
        w_alu    = (w_op_imm || w_op) ? alu_op_t'(w_f3) : ALU_ADD;
    end

    // Output registers: one cycle of latency, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_imm12  <= 12'h000;
            r_rf_we  <= 1'b0;
            r_alu_op <= ALU_ADD;
        end else begin
            r_imm12  <= w_imm;
            r_rf_we  <= w_we;
            r_alu_op <= w_alu;
        end
    end

    assign imm12  = r_imm12;
    assign rf_we  = r_rf_we;
    assign alu_op = r_alu_op;

`ifdef CTRL_ILLEGAL_FLAG_EN
    logic r_illegal;

    // Flag anything outside the four supported classes, same timing as the rest
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_illegal <= 1'b0;
        else       r_illegal <= !(w_op_imm || w_load || w_store || w_op);
    end

    assign illegal = r_illegal;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vectors plus per-cycle comparison against a spec-level decoder model
`timescale 1ns/1ps
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [11:0] imm12;
    logic        rf_we;
    logic [2:0]  alu_op;
    logic        ill_dut;

    int tests = 0;
    int fails = 0;

    control_unit dut (
        .clk    (clk),
        .reset  (reset),
        .instr  (instr),
        .imm12  (imm12),
        .rf_we  (rf_we),
        .alu_op (alu_op)
`ifdef CTRL_ILLEGAL_FLAG_EN
        ,
        .illegal(ill_dut)
`endif
    );

`ifndef CTRL_ILLEGAL_FLAG_EN
    assign ill_dut = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference decoder: returns {illegal, rf_we, alu_op, imm12}
    function automatic logic [16:0] model(input logic [31:0] x);
        int unsigned opc, f3, f7, ii, si;
        logic [16:0] r;
        opc = x & 32'h7F;
        f3  = (x >> 12) & 7;
        f7  = x >> 25;
        ii  = x >> 20;
        si  = (f7 << 5) | ((x >> 7) & 31);
        r   = 17'h0;
        if (opc == 19 && !((f3 == 1 || f3 == 5) && f7 != 0))
            r = {1'b0, 1'b1, f3[2:0], ii[11:0]};
        else if (opc == 3)
            r = {1'b0, 1'b1, 3'd0, ii[11:0]};
        else if (opc == 35)
            r = {1'b0, 1'b0, 3'd0, si[11:0]};
        else if (opc == 51 && f7 == 0)
            r = {1'b0, 1'b1, f3[2:0], 12'h000};
        else
            r = {1'b1, 16'h0};
        return r;
    endfunction

    logic [16:0] exp_q = 17'h0;

    // Expected registered outputs track the instruction seen at each edge
    always @(posedge clk or posedge reset) begin
        if (reset) exp_q <= 17'h0;
        else       exp_q <= model(instr);
    end

    function automatic logic [16:0] dut_vec();
`ifdef CTRL_ILLEGAL_FLAG_EN
        return {ill_dut, rf_we, alu_op, imm12};
`else
        return {1'b0, rf_we, alu_op, imm12};
`endif
    endfunction

    function automatic logic [16:0] mask_ill(input logic [16:0] v);
`ifdef CTRL_ILLEGAL_FLAG_EN
        return v;
`else
        return {1'b0, v[15:0]};
`endif
    endfunction

    // Per-cycle model comparison, away from the active edge
    always @(negedge clk) begin
        tests++;
        if (dut_vec() !== mask_ill(exp_q)) begin
            fails++;
            $display("FAIL model_cmp t=%0t instr=%08h got=%05h want=%05h", $time, instr, dut_vec(), mask_ill(exp_q));
        end
    end

    task automatic check(input string name, input logic [11:0] ei, input logic ew,
                         input logic [2:0] eo, input logic el);
        logic [16:0] want;
        want = mask_ill({el, ew, eo, ei});
        tests++;
        if (dut_vec() !== want) begin
            fails++;
            $display("FAIL %s got=%05h want=%05h", name, dut_vec(), want);
        end
    endtask

    task automatic apply(input string name, input logic [31:0] v, input logic [11:0] ei,
                         input logic ew, input logic [2:0] eo, input logic el);
        @(posedge clk);
        #2 instr = v;
        @(posedge clk);
        #1 check(name, ei, ew, eo, el);
    endtask

    initial begin
        #1 reset = 1'b1;
        instr = 32'h00500093;
        #1 check("reset_async", 12'h000, 1'b0, 3'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1 check("reset_hold", 12'h000, 1'b0, 3'd0, 1'b0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 check("first_decode", 12'h005, 1'b1, 3'd0, 1'b0);

        apply("addi_m1",  32'hFFF00093, 12'hFFF, 1'b1, 3'b000, 1'b0);
        apply("andi",     32'h0F00F193, 12'h0F0, 1'b1, 3'b111, 1'b0);
        apply("sw_8",     32'h0020A423, 12'h008, 1'b0, 3'b000, 1'b0);
        apply("add",      32'h003100B3, 12'h000, 1'b1, 3'b000, 1'b0);
        apply("sub",      32'h403100B3, 12'h000, 1'b0, 3'b000, 1'b1);
        apply("lui",      32'h000010B7, 12'h000, 1'b0, 3'b000, 1'b1);
        apply("srai",     32'h40515093, 12'h000, 1'b0, 3'b000, 1'b1);
        apply("slli",     32'h00109093, 12'h001, 1'b1, 3'b001, 1'b0);
        apply("srli",     32'h0020D093, 12'h002, 1'b1, 3'b101, 1'b0);
        apply("xor",      32'h0020C0B3, 12'h000, 1'b1, 3'b100, 1'b0);
        apply("lw",       32'h00812083, 12'h008, 1'b1, 3'b000, 1'b0);
        apply("sw_m4",    32'hFE20AE23, 12'hFFC, 1'b0, 3'b000, 1'b0);
        apply("low_bits", 32'h00500090, 12'h000, 1'b0, 3'b000, 1'b1);
        apply("mul",      32'h023100B3, 12'h000, 1'b0, 3'b000, 1'b1);
        apply("slti",     32'h8000A093, 12'h800, 1'b1, 3'b010, 1'b0);
        apply("andi_2",   32'h0F00F193, 12'h0F0, 1'b1, 3'b111, 1'b0);

        #2 reset = 1'b1;
        #1 check("reset_mid", 12'h000, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        instr = 32'hFFF00093;
        @(posedge clk);
        #1 check("post_reset", 12'hFFF, 1'b1, 3'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
